// File: rtl/simple_8bit_processor_if.sv
// Bus bundle for simple_8bit_processor: function word and load data in, store data out.
// master drives func/dataIn and samples dataOut; slave is the processor side.
interface simple_8bit_processor_if;
    logic [7:0] dataIn;
    logic [8:0] func;
    logic [7:0] dataOut;

    modport master (
        output dataIn,
        output func,
        input  dataOut
    );

    modport slave (
        input  dataIn,
        input  func,
        output dataOut
    );
endinterface

// File: rtl/simple_8bit_processor.sv
// Single-cycle 8-bit datapath with eight registers, executing one func word per clock.
// Ports: clock, reset (async, active-high), bus (slave: dataIn, func[8:6 op|5:3 Rd|2:0 Rs], dataOut).
module simple_8bit_processor (
    input  logic                         clock,
    input  logic                         reset,
    simple_8bit_processor_if.slave       bus
);

    typedef enum logic [2:0] {
        OP_LOAD  = 3'b000,
        OP_MOV   = 3'b001,
        OP_ADD   = 3'b010,
        OP_SUB   = 3'b011,
        OP_AND   = 3'b100,
        OP_OR    = 3'b101,
        OP_XOR   = 3'b110,
        OP_STORE = 3'b111
    } op_e;

    logic [7:0] regs [8];
    logic [7:0] data_out;

    op_e        op;
    logic [2:0] rd;
    logic [2:0] rs;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] wr_data;
    logic       wr_en;
    logic       st_en;

    assign op = op_e'(bus.func[8:6]);
    assign rd = bus.func[5:3];
    assign rs = bus.func[2:0];

    // Operands are read before the edge, so Rd == Rs uses the old value.
    assign a = regs[rd];
    assign b = regs[rs];

    always_comb begin
        wr_en   = 1'b1;
        st_en   = 1'b0;
        wr_data = a;
        unique case (op)
            OP_LOAD:  wr_data = bus.dataIn;
            OP_MOV:   wr_data = b;
            OP_ADD:   wr_data = a + b;
            OP_SUB:   wr_data = a - b;
            OP_AND:   wr_data = a & b;
            OP_OR:    wr_data = a | b;
            OP_XOR:   wr_data = a ^ b;
            OP_STORE: begin
                wr_en = 1'b0;
                st_en = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) begin
                regs[i] <= 8'h00;
            end
            data_out <= 8'h00;
        end else begin
            if (wr_en) begin
                regs[rd] <= wr_data;
            end
            if (st_en) begin
                data_out <= a;
            end
        end
    end

    assign bus.dataOut = data_out;

endmodule

// File: tb/tb_simple_8bit_processor.sv
// Self-checking bench for simple_8bit_processor: directed scenarios plus random ops
// checked every cycle against a behavioural register-file model.
module tb_simple_8bit_processor;

    logic clock;
    logic reset;

    simple_8bit_processor_if bus ();

    simple_8bit_processor dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    logic [7:0] m_reg [8];
    logic [7:0] m_out;
    bit         chk_en = 1'b0;

    function automatic void check(string name, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_out = 8'h00;
    endfunction

    function automatic void model_exec(logic [2:0] op, logic [2:0] rd,
                                       logic [2:0] rs, logic [7:0] din);
        int x;
        int y;
        x = m_reg[rd];
        y = m_reg[rs];
        case (op)
            3'd0: m_reg[rd] = din;
            3'd1: m_reg[rd] = 8'(y);
            3'd2: m_reg[rd] = 8'((x + y) % 256);
            3'd3: m_reg[rd] = 8'((x - y + 256) % 256);
            3'd4: m_reg[rd] = 8'(x & y);
            3'd5: m_reg[rd] = 8'(x | y);
            3'd6: m_reg[rd] = 8'(x ^ y);
            default: m_out = 8'(x);
        endcase
    endfunction

    // Per-cycle output check, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) check("cycle_dataOut", bus.dataOut, m_out);
    end

    task automatic step(input logic [2:0] op, input logic [2:0] rd,
                        input logic [2:0] rs, input logic [7:0] din);
        @(negedge clock);
        bus.func   = {op, rd, rs};
        bus.dataIn = din;
        @(posedge clock);
        model_exec(op, rd, rs, din);
        #1;
    endtask

    task automatic store_chk(input string name, input logic [2:0] rd,
                             input logic [7:0] exp);
        step(3'd7, rd, 3'd0, 8'h00);
        check(name, bus.dataOut, exp);
        check({name, "_model"}, m_out, exp);
    endtask

    initial begin
        reset      = 1'b1;
        bus.func   = 9'h000;
        bus.dataIn = 8'h00;
        model_reset();
        repeat (2) @(negedge clock);
        check("reset_state", bus.dataOut, 8'h00);
        reset  = 1'b0;
        chk_en = 1'b1;

        // Async reset mid-run
        step(3'd0, 3'd3, 3'd0, 8'd9);
        store_chk("pre_reset_r3", 3'd3, 8'h09);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check("async_reset", bus.dataOut, 8'h00);
        @(negedge clock);
        reset = 1'b0;
        store_chk("post_reset_r3", 3'd3, 8'h00);

        // Load/add/mov/store
        step(3'd0, 3'd1, 3'd0, 8'd4);
        step(3'd0, 3'd0, 3'd0, 8'd5);
        step(3'd2, 3'd1, 3'd0, 8'h00);
        check("hold_before_store", bus.dataOut, 8'h00);
        step(3'd1, 3'd3, 3'd1, 8'h00);
        check("hold_after_mov", bus.dataOut, 8'h00);
        store_chk("mov_add_r3", 3'd3, 8'h09);

        // Sub wrap and logic chain
        step(3'd3, 3'd0, 3'd1, 8'h00);
        store_chk("sub_wrap", 3'd0, 8'hFC);
        step(3'd4, 3'd0, 3'd1, 8'h00);
        store_chk("and", 3'd0, 8'h08);
        step(3'd5, 3'd0, 3'd1, 8'h00);
        store_chk("or", 3'd0, 8'h09);
        step(3'd6, 3'd0, 3'd1, 8'h00);
        store_chk("xor", 3'd0, 8'h00);

        // Add overflow
        step(3'd0, 3'd2, 3'd0, 8'hF0);
        step(3'd0, 3'd5, 3'd0, 8'h20);
        step(3'd2, 3'd2, 3'd5, 8'h00);
        store_chk("add_overflow", 3'd2, 8'h10);

        // Self-operand
        step(3'd0, 3'd7, 3'd0, 8'h55);
        step(3'd6, 3'd7, 3'd7, 8'h00);
        store_chk("xor_self", 3'd7, 8'h00);
        step(3'd0, 3'd6, 3'd0, 8'h41);
        step(3'd2, 3'd6, 3'd6, 8'h00);
        store_chk("add_self", 3'd6, 8'h82);

        // Hold and isolation
        store_chk("hold_src", 3'd1, 8'h09);
        step(3'd0, 3'd4, 3'd0, 8'hA5);
        check("hold1", bus.dataOut, 8'h09);
        step(3'd2, 3'd4, 3'd4, 8'h00);
        check("hold2", bus.dataOut, 8'h09);
        step(3'd3, 3'd4, 3'd1, 8'h00);
        check("hold3", bus.dataOut, 8'h09);
        step(3'd6, 3'd4, 3'd2, 8'h00);
        check("hold4", bus.dataOut, 8'h09);
        step(3'd5, 3'd4, 3'd5, 8'h00);
        check("hold5", bus.dataOut, 8'h09);
        store_chk("iso_r0", 3'd0, 8'h00);
        store_chk("iso_r1", 3'd1, 8'h09);
        store_chk("iso_r2", 3'd2, 8'h10);
        store_chk("iso_r3", 3'd3, 8'h09);
        store_chk("iso_r5", 3'd5, 8'h20);
        store_chk("iso_r6", 3'd6, 8'h82);
        store_chk("iso_r7", 3'd7, 8'h00);
        store_chk("r4_value", 3'd4, m_reg[4]);

        // Random ops; STORE weighted so the model state is observed often
        for (int i = 0; i < 400; i++) begin
            logic [2:0] op;
            op = ($urandom_range(0, 3) == 0) ? 3'd7 : 3'($urandom_range(0, 7));
            step(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 8'($urandom_range(0, 255)));
        end
        for (int r = 0; r < 8; r++) begin
            store_chk("final_dump", 3'(r), m_reg[r]);
        end

        @(negedge clock);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
